// File: rtl/uart_time_report_if.sv
// Request/snapshot inputs and serial/status outputs of the UART time report transmitter.
interface uart_time_report_if;
   logic        report_req;
   logic [23:0] time_in;
   logic [31:0] date_in;
   logic        uart_tx;
   logic        busy;
   logic        done;

   modport master (output report_req, time_in, date_in, input uart_tx, busy, done);
   modport slave  (input report_req, time_in, date_in, output uart_tx, busy, done);
endinterface

// File: rtl/uart_time_report.sv
// Sends a snapshot of the RTC BCD time (and date when DATE_REPORT_EN is defined) as one
// ASCII line over UART 8N1. Without DATE_REPORT_EN the line is "HH:MM:SS\r\n".
module uart_time_report #(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned BAUD     = 9600
) (
   input  logic              clk,
   input  logic              rst,
   uart_time_report_if.slave bus
);
   localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
   localparam int unsigned CNT_W    = $clog2(BAUD_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
`ifdef DATE_REPORT_EN
   localparam int unsigned LEN = 21;
`else
   localparam int unsigned LEN = 10;
`endif
   localparam logic [4:0] CHAR_LAST = 5'(LEN - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state;
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_idx;
   logic [4:0]       char_idx;
   logic [23:0]      time_q;
`ifdef DATE_REPORT_EN
   logic [31:0]      date_q;
`endif
   logic             tx_q;
   logic             busy_q;
   logic             done_q;
   logic [7:0]       cur_char;

   function automatic logic [7:0] asc(input logic [3:0] n);
      return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : 8'h3F;
   endfunction

   always_comb begin
      cur_char = 8'h3F;
`ifdef DATE_REPORT_EN
      case (char_idx)
         5'd0:  cur_char = asc(date_q[31:28]);
         5'd1:  cur_char = asc(date_q[27:24]);
         5'd2:  cur_char = asc(date_q[23:20]);
         5'd3:  cur_char = asc(date_q[19:16]);
         5'd4:  cur_char = 8'h2D;
         5'd5:  cur_char = asc(date_q[15:12]);
         5'd6:  cur_char = asc(date_q[11:8]);
         5'd7:  cur_char = 8'h2D;
         5'd8:  cur_char = asc(date_q[7:4]);
         5'd9:  cur_char = asc(date_q[3:0]);
         5'd10: cur_char = 8'h20;
         5'd11: cur_char = asc(time_q[23:20]);
         5'd12: cur_char = asc(time_q[19:16]);
         5'd13: cur_char = 8'h3A;
         5'd14: cur_char = asc(time_q[15:12]);
         5'd15: cur_char = asc(time_q[11:8]);
         5'd16: cur_char = 8'h3A;
         5'd17: cur_char = asc(time_q[7:4]);
         5'd18: cur_char = asc(time_q[3:0]);
         5'd19: cur_char = 8'h0D;
         5'd20: cur_char = 8'h0A;
         default: cur_char = 8'h3F;
      endcase
`else
      case (char_idx)
         5'd0: cur_char = asc(time_q[23:20]);
         5'd1: cur_char = asc(time_q[19:16]);
         5'd2: cur_char = 8'h3A;
         5'd3: cur_char = asc(time_q[15:12]);
         5'd4: cur_char = asc(time_q[11:8]);
         5'd5: cur_char = 8'h3A;
         5'd6: cur_char = asc(time_q[7:4]);
         5'd7: cur_char = asc(time_q[3:0]);
         5'd8: cur_char = 8'h0D;
         5'd9: cur_char = 8'h0A;
         default: cur_char = 8'h3F;
      endcase
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         char_idx <= '0;
         time_q   <= '0;
`ifdef DATE_REPORT_EN
         date_q   <= '0;
`endif
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state == IDLE) begin
            // accepted also in the done cycle, giving back-to-back lines
            if (bus.report_req) begin
               time_q   <= bus.time_in;
`ifdef DATE_REPORT_EN
               date_q   <= bus.date_in;
`endif
               state    <= START;
               busy_q   <= 1'b1;
               tx_q     <= 1'b0;
               baud_cnt <= '0;
               bit_idx  <= '0;
               char_idx <= '0;
            end
         end else if (baud_cnt != CNT_LAST) begin
            baud_cnt <= baud_cnt + CNT_W'(1);
         end else begin
            baud_cnt <= '0;
            case (state)
               START: begin
                  state   <= DATA;
                  bit_idx <= '0;
                  tx_q    <= cur_char[0];
               end
               DATA: begin
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                     tx_q  <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx_q    <= cur_char[bit_idx + 3'd1];
                  end
               end
               STOP: begin
                  if (char_idx == CHAR_LAST) begin
                     state    <= IDLE;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                     char_idx <= '0;
                  end else begin
                     char_idx <= char_idx + 5'd1;
                     state    <= START;
                     tx_q     <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.uart_tx = tx_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
endmodule

// File: tb/tb_uart_time_report.sv
// Directed bench for uart_time_report at BAUD_DIV=16, decoding uart_tx cell by cell.
module tb_uart_time_report;
   localparam int BIT_CLKS = 16;
`ifdef DATE_REPORT_EN
   localparam int    LEN  = 21;
   localparam string DPFX = "2024-02-29 ";
`else
   localparam int    LEN  = 10;
   localparam string DPFX = "";
`endif
   localparam int LINE_CLKS = LEN * 10 * BIT_CLKS;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_time_report_if bus ();

   uart_time_report #(.CLK_FREQ(160), .BAUD(10)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc = 0, done_cnt = 0, done_cyc = 0, busy_lo = 0;
   logic [7:0] rx [0:31];

   // cyc equals the number of the most recent rising edge; status sampled just after it
   always @(posedge clk) begin
      cyc++;
      #1;
      if (bus.done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (bus.busy !== 1'b1) busy_lo++;
   end

   task automatic pulse_req(output int acc);
      @(negedge clk) bus.report_req = 1'b1;
      @(negedge clk) bus.report_req = 1'b0;
      acc = cyc;
   endtask

   // Entered on the first negedge of the start bit; returns on the last stop-bit sample.
   task automatic recv_line(input int n, output int terr);
      logic       v;
      logic [7:0] c;
      terr = 0;
      v = 1'b0;
      c = '0;
      for (int i = 0; i < 32; i++) rx[i] = 8'h00;
      for (int i = 0; i < n; i++) begin
         if (i > 0) @(negedge clk);
         for (int s = 0; s < BIT_CLKS; s++) begin
            if (s > 0) @(negedge clk);
            if (bus.uart_tx !== 1'b0) terr++;
         end
         for (int b = 0; b < 8; b++) begin
            for (int s = 0; s < BIT_CLKS; s++) begin
               @(negedge clk);
               if (s == 0) v = bus.uart_tx;
               else if (bus.uart_tx !== v) terr++;
            end
            c[b] = v;
         end
         for (int s = 0; s < BIT_CLKS; s++) begin
            @(negedge clk);
            if (bus.uart_tx !== 1'b1) terr++;
         end
         rx[i] = c;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.report_req = 1'b0;
      bus.time_in = 24'h000000;
      bus.date_in = 32'h00000000;
      repeat (3) @(negedge clk);
      total++; if (bus.uart_tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", bus.uart_tx); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
      rst = 1'b0;
      repeat (20) @(negedge clk);
      total++; if (bus.uart_tx !== 1'b1) begin bad++; $display("FAIL idle_tx got=%b want=1", bus.uart_tx); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", bus.busy); end
   endtask

   task automatic test_time_line();
      string exp;
      int acc, terr, d0, b0;
      exp = {DPFX, "23:59:59\r\n"};
      bus.time_in = 24'h235959;
      bus.date_in = 32'h20240229;
      d0 = done_cnt;
      pulse_req(acc);
      b0 = busy_lo;
      recv_line(LEN, terr);
      total++; if (terr !== 0) begin bad++; $display("FAIL line_bit_timing errors=%0d want=0", terr); end
      for (int i = 0; i < LEN; i++) begin
         total++;
         if (rx[i] !== exp[i]) begin bad++; $display("FAIL line_char%0d got=%02h want=%02h", i, rx[i], exp[i]); end
      end
      @(negedge clk);
      total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL line_done got=%b want=1", bus.done); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL line_busy_end got=%b want=0", bus.busy); end
      total++; if (done_cyc - acc !== LINE_CLKS) begin bad++; $display("FAIL line_duration got=%0d want=%0d", done_cyc - acc, LINE_CLKS); end
      total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL line_done_count got=%0d want=1", done_cnt - d0); end
      total++; if (busy_lo - b0 !== 1) begin bad++; $display("FAIL line_busy_low_cycles got=%0d want=1", busy_lo - b0); end
   endtask

   task automatic test_invalid_bcd();
      string exp;
      int acc, terr;
      exp = {DPFX, "1?:0?:00\r\n"};
      bus.time_in = 24'h1A0F00;
      bus.date_in = 32'h20240229;
      pulse_req(acc);
      recv_line(LEN, terr);
      total++; if (terr !== 0) begin bad++; $display("FAIL bcd_bit_timing errors=%0d want=0", terr); end
      for (int i = 0; i < LEN; i++) begin
         total++;
         if (rx[i] !== exp[i]) begin bad++; $display("FAIL bcd_char%0d got=%02h want=%02h", i, rx[i], exp[i]); end
      end
      @(negedge clk);
      total++; if (done_cyc - acc !== LINE_CLKS) begin bad++; $display("FAIL bcd_duration got=%0d want=%0d", done_cyc - acc, LINE_CLKS); end
   endtask

   task automatic test_snapshot();
      string exp;
      int acc, terr, d0;
      exp = {DPFX, "23:59:59\r\n"};
      bus.time_in = 24'h235959;
      bus.date_in = 32'h20240229;
      d0 = done_cnt;
      pulse_req(acc);
      fork
         recv_line(LEN, terr);
         begin
            repeat (400) @(negedge clk);
            bus.time_in = 24'h111111;
            bus.date_in = 32'h19991231;
            bus.report_req = 1'b1;
            @(negedge clk) bus.report_req = 1'b0;
            repeat (700) @(negedge clk);
            bus.report_req = 1'b1;
            @(negedge clk) bus.report_req = 1'b0;
         end
      join
      total++; if (terr !== 0) begin bad++; $display("FAIL snap_bit_timing errors=%0d want=0", terr); end
      for (int i = 0; i < LEN; i++) begin
         total++;
         if (rx[i] !== exp[i]) begin bad++; $display("FAIL snap_char%0d got=%02h want=%02h", i, rx[i], exp[i]); end
      end
      @(negedge clk);
      total++; if (done_cyc - acc !== LINE_CLKS) begin bad++; $display("FAIL snap_duration got=%0d want=%0d", done_cyc - acc, LINE_CLKS); end
      repeat (50) @(negedge clk);
      total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL snap_done_count got=%0d want=1", done_cnt - d0); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL snap_no_queue_busy got=%b want=0", bus.busy); end
   endtask

   task automatic test_back_to_back();
      string exp1, exp2;
      int acc1, acc2, terr;
      exp1 = {DPFX, "12:34:56\r\n"};
      exp2 = {DPFX, "07:08:09\r\n"};
      bus.time_in = 24'h123456;
      bus.date_in = 32'h20240229;
      pulse_req(acc1);
      recv_line(LEN, terr);
      bus.time_in = 24'h070809;
      // the first negedge inside pulse_req is the done cycle of line one
      pulse_req(acc2);
      total++; if (terr !== 0) begin bad++; $display("FAIL b2b1_bit_timing errors=%0d want=0", terr); end
      for (int i = 0; i < LEN; i++) begin
         total++;
         if (rx[i] !== exp1[i]) begin bad++; $display("FAIL b2b1_char%0d got=%02h want=%02h", i, rx[i], exp1[i]); end
      end
      total++; if (done_cyc - acc1 !== LINE_CLKS) begin bad++; $display("FAIL b2b1_duration got=%0d want=%0d", done_cyc - acc1, LINE_CLKS); end
      total++; if (acc2 - acc1 !== LINE_CLKS + 1) begin bad++; $display("FAIL b2b_restart got=%0d want=%0d", acc2 - acc1, LINE_CLKS + 1); end
      recv_line(LEN, terr);
      total++; if (terr !== 0) begin bad++; $display("FAIL b2b2_bit_timing errors=%0d want=0", terr); end
      for (int i = 0; i < LEN; i++) begin
         total++;
         if (rx[i] !== exp2[i]) begin bad++; $display("FAIL b2b2_char%0d got=%02h want=%02h", i, rx[i], exp2[i]); end
      end
      @(negedge clk);
      total++; if (done_cyc - acc2 !== LINE_CLKS) begin bad++; $display("FAIL b2b2_duration got=%0d want=%0d", done_cyc - acc2, LINE_CLKS); end
   endtask

   task automatic test_reset_mid();
      string exp;
      int acc, terr, d0;
      exp = {DPFX, "01:02:03\r\n"};
      bus.time_in = 24'h235959;
      bus.date_in = 32'h20240229;
      pulse_req(acc);
      repeat (5 * 10 * BIT_CLKS + BIT_CLKS + 40) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total++; if (bus.uart_tx !== 1'b1) begin bad++; $display("FAIL rstmid_tx got=%b want=1", bus.uart_tx); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", bus.busy); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b want=0", bus.done); end
      rst = 1'b0;
      d0 = done_cnt;
      repeat (LINE_CLKS) @(negedge clk);
      total++; if (done_cnt - d0 !== 0) begin bad++; $display("FAIL rstmid_stray_done got=%0d want=0", done_cnt - d0); end
      total++; if (bus.uart_tx !== 1'b1) begin bad++; $display("FAIL rstmid_idle_tx got=%b want=1", bus.uart_tx); end
      bus.time_in = 24'h010203;
      pulse_req(acc);
      recv_line(LEN, terr);
      total++; if (terr !== 0) begin bad++; $display("FAIL fresh_bit_timing errors=%0d want=0", terr); end
      for (int i = 0; i < LEN; i++) begin
         total++;
         if (rx[i] !== exp[i]) begin bad++; $display("FAIL fresh_char%0d got=%02h want=%02h", i, rx[i], exp[i]); end
      end
      @(negedge clk);
      total++; if (done_cyc - acc !== LINE_CLKS) begin bad++; $display("FAIL fresh_duration got=%0d want=%0d", done_cyc - acc, LINE_CLKS); end
      total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL fresh_done_count got=%0d want=1", done_cnt - d0); end
   endtask

   initial begin
      test_reset();
      test_time_line();
      test_invalid_bcd();
      test_snapshot();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
